// File: rtl/cpu_data_arbiter.sv
// Round-robin arbiter that merges per-CPU payload streams into one registered
// output beat, and reports completion once every CPU is done and the output has drained.
module cpu_data_arbiter #(
    parameter int unsigned CPU_NB = 4,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned IDX_W = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CPU_NB-1:0]        req_vld,
    input  logic [CPU_NB*DATA_W-1:0] req_data,
    output logic [CPU_NB-1:0]        req_rdy,
    input  logic [CPU_NB-1:0]        req_done,
    output logic                     out_vld,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_cpu_idx,
    input  logic                     out_rdy,
    output logic                     all_done
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   last_grant_q;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic               grant_vld;
    logic               out_free;
    logic               fire;
    logic [CNT_W-1:0]   beat_cnt_q [CPU_NB];

    // Round-robin search starting one past the last granted CPU.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < CPU_NB; k++) begin
            cand = IDX_W'((32'(last_grant_q) + 32'(k) + 32'd1) % CPU_NB);
            if (!grant_vld && req_vld[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign out_free = !out_vld || out_rdy;

    always_comb begin
        req_rdy = '0;
        if (!rst && out_free && (state_q != ST_DONE) && grant_vld) begin
            req_rdy[grant_idx] = 1'b1;
        end
    end

    assign fire     = |req_rdy;
    assign all_done = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (&req_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!(&req_done))                 state_d = ST_RUN;
                else if (req_vld == '0 && !out_vld) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Output register: a new grant overwrites a draining beat with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld      <= 1'b0;
            out_data     <= '0;
            out_cpu_idx  <= '0;
            last_grant_q <= IDX_W'(CPU_NB - 1);
        end else if (fire) begin
            out_vld      <= 1'b1;
            out_data     <= req_data[32'(grant_idx) * DATA_W +: DATA_W];
            out_cpu_idx  <= grant_idx;
            last_grant_q <= grant_idx;
        end else if (out_rdy) begin
            out_vld      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CPU_NB; i++) beat_cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < CPU_NB; i++) begin
                if (req_rdy[i]) beat_cnt_q[i] <= beat_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Every accepted beat advances its source CPU's counter by exactly one.
    for (genvar g = 0; g < CPU_NB; g++) begin : g_cnt_chk
        assert property (@(posedge clk) disable iff (rst)
            (req_rdy[g] && req_vld[g]) |=> (beat_cnt_q[g] == $past(beat_cnt_q[g]) + CNT_W'(1)));
    end

endmodule

// File: tb/tb_cpu_data_arbiter.sv
// Directed and scoreboard bench for cpu_data_arbiter (CPU_NB=4, DATA_W=64).
module tb_cpu_data_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_vld;
    logic [255:0] req_data;
    logic [3:0]   req_rdy;
    logic [3:0]   req_done;
    logic         out_vld;
    logic [63:0]  out_data;
    logic [1:0]   out_cpu_idx;
    logic         out_rdy;
    logic         all_done;

    int vec;
    int errs;

    cpu_data_arbiter #(.CPU_NB(4), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy), .req_done(req_done),
        .out_vld(out_vld), .out_data(out_data), .out_cpu_idx(out_cpu_idx),
        .out_rdy(out_rdy), .all_done(all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sb_word(int cpu, int s);
        return {8'(cpu), 24'h0, 32'(s)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_vld = 4'hF; req_done = 4'h0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'h1111_0000_0000_0000 | 64'(i);
        tick(); tick();
        vec++; if (out_vld !== 1'b0)     begin errs++; $display("FAIL reset_out_vld: got %0b want 0", out_vld); end
        vec++; if (out_data !== 64'h0)   begin errs++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        vec++; if (out_cpu_idx !== 2'd0) begin errs++; $display("FAIL reset_out_idx: got %0d want 0", out_cpu_idx); end
        vec++; if (all_done !== 1'b0)    begin errs++; $display("FAIL reset_all_done: got %0b want 0", all_done); end
        vec++; if (req_rdy !== 4'h0)     begin errs++; $display("FAIL reset_req_rdy: got %b want 0000", req_rdy); end
        rst = 1'b0; req_vld = 4'h0;
        tick();
    endtask

    task automatic test_single();
        req_vld = 4'b0100; req_data[2*64 +: 64] = 64'hDEAD_BEEF_0000_0001; out_rdy = 1'b1;
        #1;
        vec++; if (req_rdy !== 4'b0100) begin errs++; $display("FAIL single_req_rdy: got %b want 0100", req_rdy); end
        tick();
        req_vld = 4'h0;
        vec++; if (out_vld !== 1'b1) begin errs++; $display("FAIL single_out_vld: got %0b want 1", out_vld); end
        vec++; if (out_data !== 64'hDEAD_BEEF_0000_0001) begin errs++; $display("FAIL single_out_data: got %h want deadbeef00000001", out_data); end
        vec++; if (out_cpu_idx !== 2'd2) begin errs++; $display("FAIL single_out_idx: got %0d want 2", out_cpu_idx); end
        tick();
        vec++; if (out_vld !== 1'b0) begin errs++; $display("FAIL single_drain: got %0b want 0", out_vld); end
    endtask

    task automatic test_fairness();
        rst = 1'b1;
        tick();
        rst = 1'b0; out_rdy = 1'b1; req_vld = 4'hF;
        for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'hF00D_0000_0000_0000 | 64'(i);
        for (int k = 0; k < 6; k++) begin
            tick();
            vec++; if (out_vld !== 1'b1) begin errs++; $display("FAIL fair_vld[%0d]: got %0b want 1", k, out_vld); end
            vec++; if (out_cpu_idx !== 2'(k % 4)) begin errs++; $display("FAIL fair_idx[%0d]: got %0d want %0d", k, out_cpu_idx, k % 4); end
            vec++; if (out_data !== (64'hF00D_0000_0000_0000 | 64'(k % 4))) begin errs++; $display("FAIL fair_data[%0d]: got %h want %h", k, out_data, 64'hF00D_0000_0000_0000 | 64'(k % 4)); end
        end
        req_vld = 4'h0;
        tick();
        vec++; if (out_vld !== 1'b0) begin errs++; $display("FAIL fair_drain: got %0b want 0", out_vld); end
    endtask

    task automatic test_backpressure();
        req_vld = 4'b0010; req_data[1*64 +: 64] = 64'hAAAA_0000_0000_0001; out_rdy = 1'b1;
        #1;
        vec++; if (req_rdy !== 4'b0010) begin errs++; $display("FAIL bp_first_rdy: got %b want 0010", req_rdy); end
        tick();
        req_vld = 4'b1000; req_data[3*64 +: 64] = 64'hBBBB_0000_0000_0003; out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            vec++; if (req_rdy !== 4'h0) begin errs++; $display("FAIL bp_stall_rdy[%0d]: got %b want 0000", k, req_rdy); end
            tick();
            vec++; if (out_vld !== 1'b1 || out_cpu_idx !== 2'd1 || out_data !== 64'hAAAA_0000_0000_0001) begin
                errs++; $display("FAIL bp_hold[%0d]: got vld=%0b idx=%0d data=%h want vld=1 idx=1 data=aaaa000000000001", k, out_vld, out_cpu_idx, out_data);
            end
        end
        out_rdy = 1'b1;
        #1;
        vec++; if (req_rdy !== 4'b1000) begin errs++; $display("FAIL bp_release_rdy: got %b want 1000", req_rdy); end
        tick();
        req_vld = 4'h0;
        vec++; if (out_vld !== 1'b1 || out_cpu_idx !== 2'd3 || out_data !== 64'hBBBB_0000_0000_0003) begin
            errs++; $display("FAIL bp_next: got vld=%0b idx=%0d data=%h want vld=1 idx=3 data=bbbb000000000003", out_vld, out_cpu_idx, out_data);
        end
        tick();
        vec++; if (out_vld !== 1'b0) begin errs++; $display("FAIL bp_drain: got %0b want 0", out_vld); end
    endtask

    task automatic test_completion();
        req_vld = 4'b0001; req_data[0 +: 64] = 64'hCCCC_0000_0000_0000; req_done = 4'hF; out_rdy = 1'b1;
        #1;
        vec++; if (req_rdy !== 4'b0001) begin errs++; $display("FAIL done_last_rdy: got %b want 0001", req_rdy); end
        tick();
        req_vld = 4'h0;
        vec++; if (out_vld !== 1'b1 || out_cpu_idx !== 2'd0 || out_data !== 64'hCCCC_0000_0000_0000) begin
            errs++; $display("FAIL done_last_beat: got vld=%0b idx=%0d data=%h want vld=1 idx=0 data=cccc000000000000", out_vld, out_cpu_idx, out_data);
        end
        vec++; if (all_done !== 1'b0) begin errs++; $display("FAIL done_early1: got %0b want 0", all_done); end
        tick();
        vec++; if (out_vld !== 1'b0) begin errs++; $display("FAIL done_drained: got %0b want 0", out_vld); end
        vec++; if (all_done !== 1'b0) begin errs++; $display("FAIL done_early2: got %0b want 0", all_done); end
        tick();
        vec++; if (all_done !== 1'b1) begin errs++; $display("FAIL done_asserted: got %0b want 1", all_done); end
        req_vld = 4'hF;
        #1;
        vec++; if (req_rdy !== 4'h0) begin errs++; $display("FAIL done_rdy_stuck: got %b want 0000", req_rdy); end
        tick();
        vec++; if (out_vld !== 1'b0) begin errs++; $display("FAIL done_no_beat: got %0b want 0", out_vld); end
        req_done = 4'h0;
        tick();
        vec++; if (all_done !== 1'b1) begin errs++; $display("FAIL done_terminal: got %0b want 1", all_done); end
    endtask

    task automatic test_reset_midstream();
        rst = 1'b1;
        #1;
        vec++; if (all_done !== 1'b0) begin errs++; $display("FAIL mid_all_done_clear: got %0b want 0", all_done); end
        tick();
        rst = 1'b0; req_done = 4'h0; req_vld = 4'hF; out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'h5555_0000_0000_0000 | 64'(i);
        tick();
        vec++; if (out_vld !== 1'b1 || out_cpu_idx !== 2'd0) begin errs++; $display("FAIL mid_prime: got vld=%0b idx=%0d want vld=1 idx=0", out_vld, out_cpu_idx); end
        #2;
        rst = 1'b1;
        #1;
        vec++; if (out_vld !== 1'b0) begin errs++; $display("FAIL mid_async_vld: got %0b want 0", out_vld); end
        vec++; if (req_rdy !== 4'h0) begin errs++; $display("FAIL mid_rdy: got %b want 0000", req_rdy); end
        vec++; if (all_done !== 1'b0) begin errs++; $display("FAIL mid_all_done: got %0b want 0", all_done); end
        tick();
        rst = 1'b0; out_rdy = 1'b1;
        #1;
        vec++; if (req_rdy !== 4'b0001) begin errs++; $display("FAIL mid_first_rdy: got %b want 0001", req_rdy); end
        tick();
        vec++; if (out_vld !== 1'b1 || out_cpu_idx !== 2'd0 || out_data !== 64'h5555_0000_0000_0000) begin
            errs++; $display("FAIL mid_first_beat: got vld=%0b idx=%0d data=%h want vld=1 idx=0 data=5555000000000000", out_vld, out_cpu_idx, out_data);
        end
        req_vld = 4'h0;
        tick();
    endtask

    task automatic test_scoreboard();
        int seq [4];
        int exp_seq [4];
        int idx;
        int total;
        logic [63:0] exp;
        total = 0;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; exp_seq[i] = 0; end
        for (int n = 0; n < 10004; n++) begin
            for (int i = 0; i < 4; i++) begin
                req_vld[i] = (n < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
                req_data[i*64 +: 64] = sb_word(i, seq[i]);
            end
            out_rdy = (n < 10000) ? ($urandom_range(0, 9) < 7) : 1'b1;
            #1;
            vec++; if ($countones(req_rdy) > 1 || (req_rdy & ~req_vld) !== 4'h0) begin
                errs++; $display("FAIL sb_rdy[%0d]: got rdy=%b vld=%b want one-hot subset of vld", n, req_rdy, req_vld);
            end
            if (out_vld && out_rdy) begin
                idx = int'(out_cpu_idx);
                exp = sb_word(idx, exp_seq[idx]);
                vec++; if (out_data !== exp || exp_seq[idx] >= seq[idx]) begin
                    errs++; $display("FAIL sb_beat[%0d]: got %h from cpu %0d want %h (issued %0d)", n, out_data, idx, exp, seq[idx]);
                end
                exp_seq[idx]++;
                total++;
            end
            for (int i = 0; i < 4; i++) if (req_vld[i] && req_rdy[i]) seq[i]++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            vec++; if (exp_seq[i] !== seq[i]) begin errs++; $display("FAIL sb_count[%0d]: got %0d delivered want %0d accepted", i, exp_seq[i], seq[i]); end
        end
        vec++; if (total < 1000) begin errs++; $display("FAIL sb_total: got %0d beats want >= 1000", total); end
    endtask

    initial begin
        vec = 0; errs = 0;
        rst = 1'b1; req_vld = '0; req_data = '0; req_done = '0; out_rdy = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_completion();
        test_reset_midstream();
        test_scoreboard();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
